spi_shift_reg: RTL and testbench
================================

SPI_SHIFT_REG -- requirements
Module: spi_shift_reg

Interface
REQ-001 SHALL have these ports; one clock; reset is asynchronous and active-low.
- pclk  in  1  system clock
- preset_n  in  1  asynchronous active-low reset
- ss_i  in  1  slave select, active low; low = transfer window
- cpol_i  in  1  clock polarity
- cpha_i  in  1  clock phase
- lsbfe_i  in  1  1 = LSB first, 0 = MSB first
- send_data_i  in  1  one-pclk pulse: load tx byte
- receive_data_i  in  1  one-pclk pulse: publish rx byte
- data_mosi_i  in  8  byte to transmit
- miso_i  in  1  serial input from slave
- mosi_s_sclk_i / mosi_s_sclk0_i  in  1 each  one-pclk transmit-edge flags from baud generator
- miso_r_sclk_i / miso_r_sclk0_i  in  1 each  one-pclk sample-edge flags from baud generator
- mosi_o  out  1  serial output
- data_miso_o  out  8  last completed received byte
- busy_o  out  1  byte loaded, transfer not complete
- byte_done_o  out  1  one-pclk pulse on 8th sampled bit

Function
REQ-002 SHALL select flags: cpol_i==cpha_i -> mosi_s_sclk0_i/miso_r_sclk0_i; otherwise mosi_s_sclk_i/miso_r_sclk_i.
REQ-003 SHALL, on send_data_i with ss_i high and busy_o low, load data_mosi_i into tx register, latch lsbfe_i, set busy_o next cycle.
REQ-004 SHALL ignore send_data_i while ss_i low or busy_o high.
REQ-005 SHALL keep states IDLE, LOADED, SHIFT; IDLE->LOADED on accepted load; LOADED->SHIFT when ss_i low; SHIFT->IDLE after 8th sample or on ss_i rising.
REQ-006 SHALL drive mosi_o with first bit (bit7 MSB-first, bit0 LSB-first) on LOADED->SHIFT transition cycle.
REQ-007 SHALL advance tx bit index by one on each selected transmit flag in SHIFT and drive the new bit on mosi_o the next pclk; flags beyond 8 bits are ignored.
REQ-008 SHALL store sampled bit into rx temp register at rx index (7..0 MSB-first, 0..7 LSB-first) on each selected sample flag in SHIFT.
REQ-009 SHALL pulse byte_done_o one pclk after the 8th sample; busy_o clears same cycle.
REQ-010 SHALL copy rx temp register to data_miso_o on receive_data_i only if a completed, unpublished byte exists; otherwise data_miso_o holds.
REQ-011 SHALL process transmit and sample flags arriving in the same cycle independently.
REQ-012 SHALL, on ss_i rising mid-byte, abort: indices to start, busy_o low, no byte_done_o, data_miso_o unchanged, mosi_o held.
REQ-013 SHALL ignore lsbfe_i changes after load until next load.

Reset
REQ-014 SHALL on preset_n low: mosi_o=0, data_miso_o=8'h00, busy_o=0, byte_done_o=0, tx/rx registers 0, indices at start, state IDLE.
REQ-015 SHALL abandon any transfer on reset mid-operation; first valid load after release starts a fresh byte.

Configuration
REQ-016 SHALL, with SPI_SHIFT_LOOPBACK_EN defined, add input loopback_i (1 bit); when high, sample mosi_o instead of miso_i.
REQ-017 SHALL, without SPI_SHIFT_LOOPBACK_EN, omit loopback_i and always sample miso_i.

Verification
REQ-018 cpol=0,cpha=0, MSB-first, load 8'hA5, miso stream 8'h3C, receive_data_i pulse -> mosi_o 1,0,1,0,0,1,0,1; byte_done_o once; data_miso_o=8'h3C.
REQ-019 cpol=0,cpha=1, LSB-first, load 8'h81, miso 8'h0F (LSB first) -> mosi_o 1,0,0,0,0,0,0,1; sclk flags used; data_miso_o=8'h0F.
REQ-020 ss_i high after 4 samples -> busy_o=0, no byte_done_o, data_miso_o keeps prior 8'h3C.
REQ-021 preset_n low mid-byte -> all outputs reset values; next 8'h5A load transfers correctly.
REQ-022 send_data_i during SHIFT with 8'hFF -> ignored, current byte completes unchanged.
REQ-023 SPI_SHIFT_LOOPBACK_EN, loopback_i=1, load 8'hC3 -> data_miso_o=8'hC3 regardless of miso_i.

Source files
------------

// File: rtl/spi_shift_reg.sv
// SPI byte shift register: serialises a loaded byte and assembles a received byte.
// Optional SPI_SHIFT_LOOPBACK_EN adds loopback_i to sample mosi_o instead of miso_i.
module spi_shift_reg (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       ss_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic       lsbfe_i,
    input  logic       send_data_i,
    input  logic       receive_data_i,
    input  logic [7:0] data_mosi_i,
    input  logic       miso_i,
    input  logic       mosi_s_sclk_i,
    input  logic       mosi_s_sclk0_i,
    input  logic       miso_r_sclk_i,
    input  logic       miso_r_sclk0_i,
`ifdef SPI_SHIFT_LOOPBACK_EN
    input  logic       loopback_i,
`endif
    output logic       mosi_o,
    output logic [7:0] data_miso_o,
    output logic       busy_o,
    output logic       byte_done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] tx_reg;
    logic [7:0] rx_tmp;
    logic [2:0] tx_cnt;
    logic [2:0] rx_cnt;
    logic       lsb_q;
    logic       rx_full;

    logic       tx_flag;
    logic       rx_flag;
    logic       rx_bit;
    logic [2:0] tx_nxt;
    logic [2:0] tx_pos;
    logic [2:0] rx_pos;

    // Matching polarity/phase uses the sclk0 edge flags.
    assign tx_flag = (cpol_i == cpha_i) ? mosi_s_sclk0_i : mosi_s_sclk_i;
    assign rx_flag = (cpol_i == cpha_i) ? miso_r_sclk0_i : miso_r_sclk_i;

`ifdef SPI_SHIFT_LOOPBACK_EN
    assign rx_bit = loopback_i ? mosi_o : miso_i;
`else
    assign rx_bit = miso_i;
`endif

    assign tx_nxt = tx_cnt + 3'd1;
    assign tx_pos = lsb_q ? tx_nxt : ~tx_nxt;
    assign rx_pos = lsb_q ? rx_cnt : ~rx_cnt;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state       <= IDLE;
            tx_reg      <= 8'h00;
            rx_tmp      <= 8'h00;
            tx_cnt      <= 3'd0;
            rx_cnt      <= 3'd0;
            lsb_q       <= 1'b0;
            rx_full     <= 1'b0;
            mosi_o      <= 1'b0;
            data_miso_o <= 8'h00;
            busy_o      <= 1'b0;
            byte_done_o <= 1'b0;
        end else begin
            byte_done_o <= 1'b0;
            if (receive_data_i && rx_full) begin
                data_miso_o <= rx_tmp;
                rx_full     <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (send_data_i && ss_i && !busy_o) begin
                        tx_reg <= data_mosi_i;
                        lsb_q  <= lsbfe_i;
                        busy_o <= 1'b1;
                        tx_cnt <= 3'd0;
                        rx_cnt <= 3'd0;
                        state  <= LOADED;
                    end
                end
                LOADED: begin
                    if (!ss_i) begin
                        state   <= SHIFT;
                        mosi_o  <= lsb_q ? tx_reg[0] : tx_reg[7];
                        rx_full <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (ss_i) begin
                        // Abort: mosi_o keeps its last level.
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        tx_cnt <= 3'd0;
                        rx_cnt <= 3'd0;
                    end else begin
                        if (tx_flag && tx_cnt != 3'd7) begin
                            tx_cnt <= tx_nxt;
                            mosi_o <= tx_reg[tx_pos];
                        end
                        if (rx_flag) begin
                            rx_tmp[rx_pos] <= rx_bit;
                            rx_cnt         <= rx_cnt + 3'd1;
                            if (rx_cnt == 3'd7) begin
                                state       <= IDLE;
                                busy_o      <= 1'b0;
                                byte_done_o <= 1'b1;
                                rx_full     <= 1'b1;
                                tx_cnt      <= 3'd0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_reg.sv
// Self-checking bench for spi_shift_reg: vector table, random transfers, corner cases.
module tb_spi_shift_reg;

    logic       pclk = 1'b0;
    logic       preset_n;
    logic       ss_i;
    logic       cpol_i;
    logic       cpha_i;
    logic       lsbfe_i;
    logic       send_data_i;
    logic       receive_data_i;
    logic [7:0] data_mosi_i;
    logic       miso_i;
    logic       mosi_s_sclk_i;
    logic       mosi_s_sclk0_i;
    logic       miso_r_sclk_i;
    logic       miso_r_sclk0_i;
`ifdef SPI_SHIFT_LOOPBACK_EN
    logic       loopback_i;
`endif
    logic       mosi_o;
    logic [7:0] data_miso_o;
    logic       busy_o;
    logic       byte_done_o;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    spi_shift_reg dut (
        .pclk           (pclk),
        .preset_n       (preset_n),
        .ss_i           (ss_i),
        .cpol_i         (cpol_i),
        .cpha_i         (cpha_i),
        .lsbfe_i        (lsbfe_i),
        .send_data_i    (send_data_i),
        .receive_data_i (receive_data_i),
        .data_mosi_i    (data_mosi_i),
        .miso_i         (miso_i),
        .mosi_s_sclk_i  (mosi_s_sclk_i),
        .mosi_s_sclk0_i (mosi_s_sclk0_i),
        .miso_r_sclk_i  (miso_r_sclk_i),
        .miso_r_sclk0_i (miso_r_sclk0_i),
`ifdef SPI_SHIFT_LOOPBACK_EN
        .loopback_i     (loopback_i),
`endif
        .mosi_o         (mosi_o),
        .data_miso_o    (data_miso_o),
        .busy_o         (busy_o),
        .byte_done_o    (byte_done_o)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (byte_done_o) done_cnt++;

    typedef struct {
        bit       cpol;
        bit       cpha;
        bit       lsb;
        bit [7:0] tx;
        bit [7:0] rx;
        bit [7:0] exp_seq;
        bit [7:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic bit sel0();
        return cpol_i == cpha_i;
    endfunction

    task automatic set_tx(input bit v);
        if (sel0()) mosi_s_sclk0_i = v;
        else mosi_s_sclk_i = v;
    endtask

    task automatic set_rx(input bit v);
        if (sel0()) miso_r_sclk0_i = v;
        else miso_r_sclk_i = v;
    endtask

    // Pulse the unselected flag pair plus a stray send of 8'hFF.
    task automatic noise;
        if (sel0()) begin
            mosi_s_sclk_i = 1'b1;
            miso_r_sclk_i = 1'b1;
        end else begin
            mosi_s_sclk0_i = 1'b1;
            miso_r_sclk0_i = 1'b1;
        end
        send_data_i = 1'b1;
        data_mosi_i = 8'hFF;
        tick;
        mosi_s_sclk_i  = 1'b0;
        miso_r_sclk_i  = 1'b0;
        mosi_s_sclk0_i = 1'b0;
        miso_r_sclk0_i = 1'b0;
        send_data_i    = 1'b0;
    endtask

    // Model: order in which tx bits appear on the wire.
    function automatic bit [7:0] wire_seq(input bit lsb, input bit [7:0] b);
        bit [7:0] s;
        for (int i = 0; i < 8; i++) s[7-i] = lsb ? b[i] : b[7-i];
        return s;
    endfunction

    task automatic xfer(input bit cpol, input bit cpha, input bit lsb,
                        input bit [7:0] tx, input bit [7:0] rx,
                        input bit [7:0] exp_seq, input bit [7:0] exp_data,
                        input bit lb);
        int d0;
        bit [7:0] rs;
        d0 = done_cnt;
        rs = wire_seq(lsb, rx);
        cpol_i = cpol;
        cpha_i = cpha;
        ss_i = 1'b1;
        lsbfe_i = lsb;
        data_mosi_i = tx;
        send_data_i = 1'b1;
        tick;
        send_data_i = 1'b0;
        lsbfe_i = ~lsb;
        check("busy_load", {7'd0, busy_o}, 8'd1);
        ss_i = 1'b0;
        tick;
        for (int i = 0; i < 8; i++) begin
            check("mosi_bit", {7'd0, mosi_o}, {7'd0, exp_seq[7-i]});
            miso_i = lb ? 1'($urandom) : rs[7-i];
            set_rx(1'b1);
            tick;
            set_rx(1'b0);
            if (i < 7) begin
                noise;
                set_tx(1'b1);
                tick;
                set_tx(1'b0);
            end
        end
        check("byte_done", {7'd0, byte_done_o}, 8'd1);
        check("busy_done", {7'd0, busy_o}, 8'd0);
        tick;
        check("done_pulse", {7'd0, byte_done_o}, 8'd0);
        ss_i = 1'b1;
        receive_data_i = 1'b1;
        tick;
        receive_data_i = 1'b0;
        check("data_miso", data_miso_o, exp_data);
        check("done_count", 8'(done_cnt - d0), 8'd1);
    endtask

    initial begin
        vecs[0] = '{0, 0, 0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{0, 1, 1, 8'h81, 8'h0F, 8'h81, 8'h0F};
        vecs[2] = '{1, 1, 0, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[3] = '{1, 0, 1, 8'h12, 8'h7E, 8'h48, 8'h7E};

        preset_n = 1'b0;
        ss_i = 1'b1;
        cpol_i = 1'b0;
        cpha_i = 1'b0;
        lsbfe_i = 1'b0;
        send_data_i = 1'b0;
        receive_data_i = 1'b0;
        data_mosi_i = 8'h00;
        miso_i = 1'b0;
        mosi_s_sclk_i = 1'b0;
        mosi_s_sclk0_i = 1'b0;
        miso_r_sclk_i = 1'b0;
        miso_r_sclk0_i = 1'b0;
`ifdef SPI_SHIFT_LOOPBACK_EN
        loopback_i = 1'b0;
`endif
        tick;
        tick;
        check("rst_mosi", {7'd0, mosi_o}, 8'd0);
        check("rst_data", data_miso_o, 8'h00);
        check("rst_busy", {7'd0, busy_o}, 8'd0);
        check("rst_done", {7'd0, byte_done_o}, 8'd0);
        preset_n = 1'b1;
        tick;

        for (int k = 0; k < 4; k++)
            xfer(vecs[k].cpol, vecs[k].cpha, vecs[k].lsb, vecs[k].tx,
                 vecs[k].rx, vecs[k].exp_seq, vecs[k].exp_data, 1'b0);

        // Abort after four samples keeps the last published byte.
        xfer(0, 0, 0, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b0);
        begin
            int d0;
            logic held;
            d0 = done_cnt;
            data_mosi_i = 8'h96;
            send_data_i = 1'b1;
            tick;
            send_data_i = 1'b0;
            ss_i = 1'b0;
            tick;
            for (int i = 0; i < 4; i++) begin
                miso_i = 1'b1;
                set_rx(1'b1);
                tick;
                set_rx(1'b0);
                set_tx(1'b1);
                tick;
                set_tx(1'b0);
            end
            held = mosi_o;
            ss_i = 1'b1;
            tick;
            check("abort_busy", {7'd0, busy_o}, 8'd0);
            check("abort_mosi", {7'd0, mosi_o}, {7'd0, held});
            tick;
            tick;
            check("abort_nodone", 8'(done_cnt - d0), 8'd0);
            receive_data_i = 1'b1;
            tick;
            receive_data_i = 1'b0;
            check("abort_data", data_miso_o, 8'h3C);
        end

        // Reset in the middle of a byte.
        data_mosi_i = 8'h33;
        send_data_i = 1'b1;
        tick;
        send_data_i = 1'b0;
        ss_i = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            miso_i = 1'b1;
            set_rx(1'b1);
            tick;
            set_rx(1'b0);
        end
        preset_n = 1'b0;
        #2;
        check("mid_rst_mosi", {7'd0, mosi_o}, 8'd0);
        check("mid_rst_data", data_miso_o, 8'h00);
        check("mid_rst_busy", {7'd0, busy_o}, 8'd0);
        check("mid_rst_done", {7'd0, byte_done_o}, 8'd0);
        ss_i = 1'b1;
        tick;
        preset_n = 1'b1;
        tick;
        xfer(0, 0, 0, 8'h5A, 8'hA6, 8'h5A, 8'hA6, 1'b0);

        for (int r = 0; r < 20; r++) begin
            bit cp, ch, lb;
            bit [7:0] t, x;
            cp = 1'($urandom);
            ch = 1'($urandom);
            lb = 1'($urandom);
            t = 8'($urandom);
            x = 8'($urandom);
            xfer(cp, ch, lb, t, x, wire_seq(lb, t), x, 1'b0);
        end

`ifdef SPI_SHIFT_LOOPBACK_EN
        loopback_i = 1'b1;
        xfer(0, 0, 0, 8'hC3, 8'h00, 8'hC3, 8'hC3, 1'b1);
        xfer(1, 0, 1, 8'h6D, 8'h00, wire_seq(1, 8'h6D), 8'h6D, 1'b1);
        loopback_i = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
